// File: rtl/sonar_pkg.sv
`default_nettype none
// ============================================================================
// Module : sonar_pkg
// Brief  : Shared state encoding and 100 MHz timing defaults for sonar_multi.
// Rev    : 1.0  initial release
// ============================================================================
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    PUBLISH   = 3'd4,
    HOLDOFF   = 3'd5
  } state_t;

  localparam int DEF_TICK_DIV      = 100;
  localparam int DEF_TRIG_CYCLES   = 1000;
  localparam int DEF_TIMEOUT_TICKS = 30000;
  localparam int DEF_HOLDOFF_TICKS = 10000;

  // Bits needed to hold the range 0..max_val, never less than one.
  function automatic int width_of(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sonar_sync.sv
`default_nettype none
// ============================================================================
// Module : sonar_sync
// Brief  : 1-bit two-flop synchronizer with registered rise/fall pulses.
// Rev    : 1.0  initial release
// ============================================================================
module sonar_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic sync_d;

  // Pin-to-pulse latency is three clocks: meta, sync, then the edge register.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
      rise   <= sync & ~sync_d;
      fall   <= ~sync & sync_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sonar_multi.sv
`default_nettype none
// ============================================================================
// Module : sonar_multi
// Brief  : Round-robin multi-channel ultrasonic ranging controller with a
//          single-entry valid/ready result port.
// Rev    : 1.0  initial release
// ============================================================================
module sonar_multi
  import sonar_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 16,
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int TRIG_CYCLES   = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int HOLDOFF_TICKS = DEF_HOLDOFF_TICKS,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] echo,
  output logic [NUM_CH-1:0] trig,
  output logic              idle,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_ch,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_timeout
);

  localparam int TICK_W = width_of(TICK_DIV - 1);
  localparam int PH_W   = width_of(max3(TRIG_CYCLES, TIMEOUT_TICKS, HOLDOFF_TICKS));

  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]   TRIG_LAST    = PH_W'(TRIG_CYCLES - 1);
  localparam logic [PH_W-1:0]   TIMEOUT_LAST = PH_W'(TIMEOUT_TICKS - 1);
  localparam logic [PH_W-1:0]   HOLD_LAST    = PH_W'(HOLDOFF_TICKS - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT  = CNT_W'(TIMEOUT_TICKS);
  localparam logic [CH_W-1:0]   LAST_CH      = CH_W'(NUM_CH - 1);

  state_t              state;
  state_t              state_next;
  logic [CH_W-1:0]     ch;
  logic [TICK_W-1:0]   presc;
  logic                tick;
  logic [PH_W-1:0]     phase_cnt;
  logic [PH_W-1:0]     phase_inc;
  logic [NUM_CH-1:0]   rise;
  logic [NUM_CH-1:0]   fall;
  logic                rise_sel;
  logic                fall_sel;
  logic                trig_done;
  logic                window_done;
  logic                hold_done;
  logic                can_load;
  logic [CNT_W-1:0]    meas_count;
  logic                meas_timeout;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
      sonar_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (echo[i]),
        .rise (rise[i]),
        .fall (fall[i])
      );
    end
  endgenerate

  assign tick        = (presc == TICK_LAST);
  assign rise_sel    = rise[ch];
  assign fall_sel    = fall[ch];
  assign phase_inc   = phase_cnt + PH_W'(tick);
  assign trig_done   = (phase_cnt == TRIG_LAST);
  assign window_done = tick && (phase_cnt == TIMEOUT_LAST);
  assign hold_done   = tick && (phase_cnt == HOLD_LAST);
  assign can_load    = !res_valid || res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (en) state_next = TRIG;
      TRIG:      if (trig_done) state_next = WAIT_RISE;
      WAIT_RISE: begin
        if (rise_sel) begin
          state_next = MEASURE;
        end else if (window_done) begin
          state_next = PUBLISH;
        end
      end
      MEASURE:   if (fall_sel || window_done) state_next = PUBLISH;
      PUBLISH:   if (can_load) state_next = HOLDOFF;
      HOLDOFF:   if (hold_done) state_next = en ? TRIG : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    trig = '0;
    if (state == TRIG) begin
      trig[ch] = 1'b1;
    end
    idle = (state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc        <= '0;
      phase_cnt    <= '0;
      ch           <= '0;
      meas_count   <= '0;
      meas_timeout <= 1'b0;
      res_valid    <= 1'b0;
      res_ch       <= '0;
      res_count    <= '0;
      res_timeout  <= 1'b0;
    end else begin
      // Every state change realigns the tick grid to the start of the phase.
      if (state_next != state || tick) begin
        presc <= '0;
      end else begin
        presc <= presc + TICK_W'(1);
      end

      if (state_next != state) begin
        phase_cnt <= '0;
      end else if (state == TRIG) begin
        phase_cnt <= phase_cnt + PH_W'(1);
      end else if (state == WAIT_RISE || state == MEASURE || state == HOLDOFF) begin
        phase_cnt <= phase_inc;
      end

      if (state == WAIT_RISE && !rise_sel && window_done) begin
        meas_count   <= '0;
        meas_timeout <= 1'b1;
      end else if (state == MEASURE && fall_sel) begin
        // Include a tick landing on the fall cycle so the result is a true floor.
        meas_count   <= CNT_W'(phase_inc);
        meas_timeout <= 1'b0;
      end else if (state == MEASURE && window_done) begin
        meas_count   <= TIMEOUT_CNT;
        meas_timeout <= 1'b1;
      end

      if (state == PUBLISH && can_load) begin
        res_valid   <= 1'b1;
        res_ch      <= ch;
        res_count   <= meas_count;
        res_timeout <= meas_timeout;
      end else if (res_ready) begin
        res_valid   <= 1'b0;
      end

      if (state == HOLDOFF && hold_done) begin
        ch <= (ch == LAST_CH) ? '0 : ch + CH_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sonar_multi.sv
`default_nettype none
// ============================================================================
// Module : tb_sonar_multi
// Brief  : Directed self-checking bench for sonar_multi with shortened timing
//          (TICK_DIV=4, TRIG_CYCLES=20, TIMEOUT_TICKS=50, HOLDOFF_TICKS=10).
// Rev    : 1.0  initial release
// ============================================================================
module tb_sonar_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  echo;
  logic [3:0]  trig;
  logic        idle;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_ch;
  logic [15:0] res_count;
  logic        res_timeout;

  int total = 0;
  int bad   = 0;

  sonar_multi #(
    .NUM_CH        (4),
    .CNT_W         (16),
    .TICK_DIV      (4),
    .TRIG_CYCLES   (20),
    .TIMEOUT_TICKS (50),
    .HOLDOFF_TICKS (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .echo        (echo),
    .trig        (trig),
    .idle        (idle),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_ch      (res_ch),
    .res_count   (res_count),
    .res_timeout (res_timeout)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_trig_on(input int limit, output int n);
    n = 0;
    while (trig == 4'b0000 && n < limit) begin step(); n++; end
  endtask

  task automatic wait_trig_off(input int limit, output int n);
    n = 0;
    while (trig != 4'b0000 && n < limit) begin step(); n++; end
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!res_valid && n < limit) begin step(); n++; end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; echo = 4'b0000; res_ready = 1'b1;
    repeat (3) step();
    total++; if (trig !== 4'b0000) begin bad++; $display("FAIL rst_trig: got %b want 0000", trig); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b want 1", idle); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", res_valid); end
    total++; if (res_ch !== 2'd0) begin bad++; $display("FAIL rst_ch: got %0d want 0", res_ch); end
    total++; if (res_count !== 16'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", res_count); end
    total++; if (res_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", res_timeout); end
    rst = 1'b0;
    step();
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL idle_no_en: got %b want 1", idle); end
  endtask

  task automatic test_trigger;
    int n, w;
    en = 1'b1;
    wait_trig_on(10, n);
    total++; if (n !== 1) begin bad++; $display("FAIL trig_start_lat: got %0d want 1", n); end
    total++; if (trig !== 4'b0001) begin bad++; $display("FAIL trig_ch0: got %b want 0001", trig); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL idle_fall: got %b want 0", idle); end
    w = 0;
    while (trig == 4'b0001 && w < 100) begin step(); w++; end
    total++; if (w !== 20) begin bad++; $display("FAIL trig_width: got %0d want 20", w); end
    total++; if (trig !== 4'b0000) begin bad++; $display("FAIL trig_after: got %b want 0000", trig); end
  endtask

  task automatic test_echo_measure;
    int n;
    repeat (5) step();
    echo[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) echo[1] = 1'b1;
      if (i == 20) echo[1] = 1'b0;
      step();
    end
    echo[0] = 1'b0;
    wait_valid(50, n);
    total++; if (n !== 5) begin bad++; $display("FAIL meas_pub_lat: got %0d want 5", n); end
    total++; if (res_ch !== 2'd0) begin bad++; $display("FAIL meas_ch: got %0d want 0", res_ch); end
    total++; if (res_count !== 16'd10) begin bad++; $display("FAIL meas_count: got %0d want 10", res_count); end
    total++; if (res_timeout !== 1'b0) begin bad++; $display("FAIL meas_timeout: got %b want 0", res_timeout); end
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL meas_valid_pulse: got %b want 0", res_valid); end
    wait_trig_on(100, n);
    total++; if (n !== 39) begin bad++; $display("FAIL holdoff_len: got %0d want 39", n); end
    total++; if (trig !== 4'b0010) begin bad++; $display("FAIL trig_ch1: got %b want 0010", trig); end
  endtask

  task automatic test_no_echo;
    int n, w;
    w = 0;
    while (trig == 4'b0010 && w < 100) begin step(); w++; end
    total++; if (w !== 20) begin bad++; $display("FAIL ch1_trig_width: got %0d want 20", w); end
    n = 0;
    while (!res_valid && n < 400) begin
      if (n == 10) echo[0] = 1'b1;
      if (n == 30) echo[0] = 1'b0;
      step(); n++;
    end
    total++; if (n !== 201) begin bad++; $display("FAIL wait_timeout_lat: got %0d want 201", n); end
    total++; if (res_ch !== 2'd1) begin bad++; $display("FAIL noecho_ch: got %0d want 1", res_ch); end
    total++; if (res_count !== 16'd0) begin bad++; $display("FAIL noecho_count: got %0d want 0", res_count); end
    total++; if (res_timeout !== 1'b1) begin bad++; $display("FAIL noecho_timeout: got %b want 1", res_timeout); end
  endtask

  task automatic test_stuck_and_saturate;
    int n;
    logic [3:0] exp_trig;
    logic [1:0] exp_ch;
    echo[2] = 1'b1;
    wait_trig_on(100, n);
    total++; if (trig !== 4'b0100) begin bad++; $display("FAIL trig_ch2: got %b want 0100", trig); end
    wait_trig_off(100, n);
    wait_valid(400, n);
    total++; if (n !== 201) begin bad++; $display("FAIL stuck_lat: got %0d want 201", n); end
    total++; if (res_ch !== 2'd2) begin bad++; $display("FAIL stuck_ch: got %0d want 2", res_ch); end
    total++; if (res_count !== 16'd0) begin bad++; $display("FAIL stuck_count: got %0d want 0", res_count); end
    total++; if (res_timeout !== 1'b1) begin bad++; $display("FAIL stuck_timeout: got %b want 1", res_timeout); end
    echo[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_ch   = 2'((3 + k) % 4);
      exp_trig = 4'b0001 << exp_ch;
      wait_trig_on(100, n);
      total++; if (trig !== exp_trig) begin bad++; $display("FAIL rr_trig: got %b want %b", trig, exp_trig); end
      wait_trig_off(100, n);
      wait_valid(400, n);
      total++; if (res_ch !== exp_ch) begin bad++; $display("FAIL rr_ch: got %0d want %0d", res_ch, exp_ch); end
    end
    wait_trig_on(100, n);
    total++; if (trig !== 4'b0100) begin bad++; $display("FAIL trig_ch2_again: got %b want 0100", trig); end
    wait_trig_off(100, n);
    repeat (5) step();
    echo[2] = 1'b1;
    wait_valid(400, n);
    total++; if (n !== 205) begin bad++; $display("FAIL sat_lat: got %0d want 205", n); end
    total++; if (res_ch !== 2'd2) begin bad++; $display("FAIL sat_ch: got %0d want 2", res_ch); end
    total++; if (res_count !== 16'd50) begin bad++; $display("FAIL sat_count: got %0d want 50", res_count); end
    total++; if (res_timeout !== 1'b1) begin bad++; $display("FAIL sat_timeout: got %b want 1", res_timeout); end
  endtask

  task automatic test_backpressure;
    int n, trig_seen, unstable;
    step();
    res_ready = 1'b0;
    echo[2]   = 1'b0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_consumed: got %b want 0", res_valid); end
    wait_trig_on(100, n);
    wait_trig_off(100, n);
    wait_valid(400, n);
    total++; if (res_ch !== 2'd3) begin bad++; $display("FAIL bp_first_ch: got %0d want 3", res_ch); end
    wait_trig_on(100, n);
    total++; if (n !== 40) begin bad++; $display("FAIL bp_holdoff: got %0d want 40", n); end
    total++; if (trig !== 4'b0001) begin bad++; $display("FAIL bp_trig_ch0: got %b want 0001", trig); end
    wait_trig_off(100, n);
    repeat (3) step();
    echo[0] = 1'b1;
    repeat (20) step();
    echo[0] = 1'b0;
    trig_seen = 0; unstable = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (trig != 4'b0000) trig_seen++;
      if (!res_valid || res_ch != 2'd3 || res_count != 16'd0 || !res_timeout) unstable++;
    end
    total++; if (trig_seen !== 0) begin bad++; $display("FAIL stall_trig: got %0d want 0", trig_seen); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL stall_hold: got %0d want 0", unstable); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL stall_idle: got %b want 0", idle); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL swap_valid: got %b want 1", res_valid); end
    total++; if (res_ch !== 2'd0) begin bad++; $display("FAIL swap_ch: got %0d want 0", res_ch); end
    total++; if (res_count !== 16'd5) begin bad++; $display("FAIL swap_count: got %0d want 5", res_count); end
    total++; if (res_timeout !== 1'b0) begin bad++; $display("FAIL swap_timeout: got %b want 0", res_timeout); end
    wait_trig_on(100, n);
    total++; if (n !== 40) begin bad++; $display("FAIL resume_lat: got %0d want 40", n); end
    total++; if (trig !== 4'b0010) begin bad++; $display("FAIL resume_trig: got %b want 0010", trig); end
  endtask

  task automatic test_reset_mid;
    int n;
    res_ready = 1'b1;
    wait_trig_off(100, n);
    wait_valid(400, n);
    step();
    res_ready = 1'b0;
    wait_trig_on(100, n);
    wait_trig_off(100, n);
    wait_valid(400, n);
    wait_trig_on(100, n);
    total++; if (trig !== 4'b1000) begin bad++; $display("FAIL mid_trig_ch3: got %b want 1000", trig); end
    wait_trig_off(100, n);
    repeat (2) step();
    echo[3] = 1'b1;
    repeat (20) step();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", res_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    echo[3] = 1'b0;
    total++; if (trig !== 4'b0000) begin bad++; $display("FAIL mid_rst_trig: got %b want 0000", trig); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", res_valid); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL mid_rst_idle: got %b want 1", idle); end
    total++; if (res_ch !== 2'd0) begin bad++; $display("FAIL mid_rst_ch: got %0d want 0", res_ch); end
    total++; if (res_count !== 16'd0) begin bad++; $display("FAIL mid_rst_count: got %0d want 0", res_count); end
    wait_trig_on(10, n);
    total++; if (n !== 1) begin bad++; $display("FAIL mid_restart_lat: got %0d want 1", n); end
    total++; if (trig !== 4'b0001) begin bad++; $display("FAIL mid_restart_ch0: got %b want 0001", trig); end
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (trig !== 4'b0000) begin bad++; $display("FAIL trig_rst_drop: got %b want 0000", trig); end
    wait_trig_on(10, n);
    total++; if (trig !== 4'b0001) begin bad++; $display("FAIL trig_rst_restart: got %b want 0001", trig); end
  endtask

  task automatic test_en_drop;
    int n, busy;
    res_ready = 1'b1;
    wait_trig_off(100, n);
    repeat (2) step();
    echo[0] = 1'b1;
    repeat (10) step();
    en = 1'b0;
    repeat (14) step();
    echo[0] = 1'b0;
    wait_valid(50, n);
    total++; if (res_ch !== 2'd0) begin bad++; $display("FAIL endrop_ch: got %0d want 0", res_ch); end
    total++; if (res_count !== 16'd6) begin bad++; $display("FAIL endrop_count: got %0d want 6", res_count); end
    total++; if (res_timeout !== 1'b0) begin bad++; $display("FAIL endrop_timeout: got %b want 0", res_timeout); end
    n = 0;
    while (idle == 1'b0 && n < 100) begin step(); n++; end
    total++; if (n !== 40) begin bad++; $display("FAIL endrop_idle_lat: got %0d want 40", n); end
    busy = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (trig != 4'b0000 || !idle) busy++;
    end
    total++; if (busy !== 0) begin bad++; $display("FAIL endrop_stays_idle: got %0d want 0", busy); end
    en = 1'b1;
    step();
    total++; if (trig !== 4'b0010) begin bad++; $display("FAIL endrop_resume_ch1: got %b want 0010", trig); end
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_echo_measure();
    test_no_echo();
    test_stuck_and_saturate();
    test_backpressure();
    test_reset_mid();
    test_en_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
